// File: rtl/iob_asym_pkg.sv
// Width helpers shared by the asymmetric converter and its FIFO controller so both
// derive lane ratios and address widths with identical formulas.
package iob_asym_pkg;

   function automatic int unsigned iob_max(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   function automatic int unsigned iob_min(input int unsigned a, input int unsigned b);
      return (a < b) ? a : b;
   endfunction

   function automatic int unsigned asym_maxdata_w(input int unsigned w_w, input int unsigned r_w);
      return iob_max(w_w, r_w);
   endfunction

   function automatic int unsigned asym_mindata_w(input int unsigned w_w, input int unsigned r_w);
      return iob_min(w_w, r_w);
   endfunction

   function automatic int unsigned asym_w_ratio(input int unsigned w_w, input int unsigned r_w);
      return w_w / iob_min(w_w, r_w);
   endfunction

   function automatic int unsigned asym_r_ratio(input int unsigned w_w, input int unsigned r_w);
      return r_w / iob_min(w_w, r_w);
   endfunction

   // Address widths count wide words: narrow-word depth minus log2 of the lane ratio
   function automatic int unsigned asym_w_addr_w(input int unsigned w_w, input int unsigned r_w,
                                                 input int unsigned addr_w);
      return addr_w - 32'($clog2(asym_w_ratio(w_w, r_w)));
   endfunction

   function automatic int unsigned asym_r_addr_w(input int unsigned w_w, input int unsigned r_w,
                                                 input int unsigned addr_w);
      return addr_w - 32'($clog2(asym_r_ratio(w_w, r_w)));
   endfunction

endpackage

// File: rtl/iob_asym_fifo_level.sv
// Fill-level accumulator in narrow-word units with registered full/empty flags
// computed from the next level, so flags never see the request inputs combinationally.
module iob_asym_fifo_level #(
   parameter int unsigned W_RATIO = 4,
   parameter int unsigned R_RATIO = 1,
   parameter int unsigned ADDR_W  = 4
) (
   input  logic            clk_i,
   input  logic            cke_i,
   input  logic            rst_i,
   input  logic            w_push_i,
   input  logic            r_pop_i,
   output logic [ADDR_W:0] level_o,
   output logic            w_full_o,
   output logic            r_empty_o
);

   localparam int unsigned      LVL_W    = ADDR_W + 1;
   localparam logic [LVL_W-1:0] W_INC    = LVL_W'(W_RATIO);
   localparam logic [LVL_W-1:0] R_DEC    = LVL_W'(R_RATIO);
   localparam logic [LVL_W-1:0] FULL_THR = LVL_W'((1 << ADDR_W) - W_RATIO);

   logic [LVL_W-1:0] level_q, level_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   always_comb begin
      level_d = level_q;
      if (w_push_i) begin
         level_d = level_d + W_INC;
      end
      if (r_pop_i) begin
         level_d = level_d - R_DEC;
      end
      full_d  = (level_d > FULL_THR);
      empty_d = (level_d < R_DEC);
   end

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
         end else begin
            level_q <= level_d;
            full_q  <= full_d;
            empty_q <= empty_d;
         end
      end
   end

   assign level_o   = level_q;
   assign w_full_o  = full_q;
   assign r_empty_o = empty_q;

endmodule

// File: rtl/iob_reg_re.sv
// Register with clock enable, synchronous reset and load enable.
module iob_reg_re #(
   parameter int unsigned       DATA_W  = 1,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk_i) begin
      if (cke_i) begin
         if (rst_i) begin
            data_q <= RST_VAL;
         end else if (en_i) begin
            data_q <= data_i;
         end
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/iob_asym_fifo_ctrl.sv
// FIFO controller for the asymmetric width converter: address/enable generation,
// narrow-unit fill tracking and full/empty flags around an external RAM.
module iob_asym_fifo_ctrl
   import iob_asym_pkg::*;
#(
   parameter int unsigned  W_DATA_W  = 32,
   parameter int unsigned  R_DATA_W  = 8,
   parameter int unsigned  ADDR_W    = 4,
   localparam int unsigned MAXDATA_W = asym_maxdata_w(W_DATA_W, R_DATA_W),
   localparam int unsigned MINDATA_W = asym_mindata_w(W_DATA_W, R_DATA_W),
   localparam int unsigned W_RATIO   = asym_w_ratio(W_DATA_W, R_DATA_W),
   localparam int unsigned R_RATIO   = asym_r_ratio(W_DATA_W, R_DATA_W),
   localparam int unsigned W_ADDR_W  = asym_w_addr_w(W_DATA_W, R_DATA_W, ADDR_W),
   localparam int unsigned R_ADDR_W  = asym_r_addr_w(W_DATA_W, R_DATA_W, ADDR_W)
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                rst_i,
   input  logic                w_en_i,
   input  logic [W_DATA_W-1:0] w_data_i,
   output logic                w_full_o,
   input  logic                r_en_i,
   output logic [R_DATA_W-1:0] r_data_o,
   output logic                r_valid_o,
   output logic                r_empty_o,
   output logic [ADDR_W:0]     level_o,
   output logic                conv_w_en_o,
   output logic [W_ADDR_W-1:0] conv_w_addr_o,
   output logic [W_DATA_W-1:0] conv_w_data_o,
   output logic                conv_r_en_o,
   output logic [R_ADDR_W-1:0] conv_r_addr_o,
   input  logic [R_DATA_W-1:0] conv_r_data_i
);

   // Widths must differ by a power-of-2 factor for the lane mapping to hold
   if (((MAXDATA_W % MINDATA_W) != 0) ||
       (((MAXDATA_W / MINDATA_W) & ((MAXDATA_W / MINDATA_W) - 1)) != 0)) begin : g_bad_width_ratio
      $error("iob_asym_fifo_ctrl: W_DATA_W and R_DATA_W must differ by a power-of-2 factor");
   end

   logic                w_push, r_pop;
   logic                w_full, r_empty;
   logic [W_ADDR_W-1:0] w_ptr_q;
   logic [R_ADDR_W-1:0] r_ptr_q;

   // Requests are qualified by the registered flags only
   assign w_push = w_en_i & ~w_full;
   assign r_pop  = r_en_i & ~r_empty;

   iob_reg_re #(.DATA_W(W_ADDR_W)) u_w_ptr (
      .clk_i  (clk_i),
      .cke_i  (cke_i),
      .rst_i  (rst_i),
      .en_i   (w_push),
      .data_i (w_ptr_q + W_ADDR_W'(1)),
      .data_o (w_ptr_q)
   );

   iob_reg_re #(.DATA_W(R_ADDR_W)) u_r_ptr (
      .clk_i  (clk_i),
      .cke_i  (cke_i),
      .rst_i  (rst_i),
      .en_i   (r_pop),
      .data_i (r_ptr_q + R_ADDR_W'(1)),
      .data_o (r_ptr_q)
   );

   // Converter read data arrives one cycle after the pop
   iob_reg_re #(.DATA_W(1)) u_r_valid (
      .clk_i  (clk_i),
      .cke_i  (cke_i),
      .rst_i  (rst_i),
      .en_i   (1'b1),
      .data_i (r_pop),
      .data_o (r_valid_o)
   );

   iob_asym_fifo_level #(
      .W_RATIO (W_RATIO),
      .R_RATIO (R_RATIO),
      .ADDR_W  (ADDR_W)
   ) u_level (
      .clk_i     (clk_i),
      .cke_i     (cke_i),
      .rst_i     (rst_i),
      .w_push_i  (w_push),
      .r_pop_i   (r_pop),
      .level_o   (level_o),
      .w_full_o  (w_full),
      .r_empty_o (r_empty)
   );

   assign w_full_o      = w_full;
   assign r_empty_o     = r_empty;
   assign conv_w_en_o   = w_push;
   assign conv_w_addr_o = w_ptr_q;
   assign conv_w_data_o = w_data_i;
   assign conv_r_en_o   = r_pop;
   assign conv_r_addr_o = r_ptr_q;
   assign r_data_o      = conv_r_data_i;

endmodule

// File: tb/tb_iob_asym_fifo_ctrl.sv
// Bench for iob_asym_fifo_ctrl in both width directions (8->32 and 32->8, 16 bytes deep),
// with a byte-addressed converter/RAM stand-in and a byte-queue reference model.
module tb_iob_asym_fifo_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic cke, rst;

   // instance A: 8-bit push, 32-bit pop
   logic        a_w_en, a_r_en, a_w_full, a_r_valid, a_r_empty;
   logic [7:0]  a_w_data;
   logic [31:0] a_r_data;
   logic [4:0]  a_level;
   logic        a_cw_en, a_cr_en;
   logic [3:0]  a_cw_addr;
   logic [7:0]  a_cw_data;
   logic [1:0]  a_cr_addr;
   logic [31:0] a_cr_data;

   // instance B: 32-bit push, 8-bit pop
   logic        b_w_en, b_r_en, b_w_full, b_r_valid, b_r_empty;
   logic [31:0] b_w_data;
   logic [7:0]  b_r_data;
   logic [4:0]  b_level;
   logic        b_cw_en, b_cr_en;
   logic [1:0]  b_cw_addr;
   logic [31:0] b_cw_data;
   logic [3:0]  b_cr_addr;
   logic [7:0]  b_cr_data;

   iob_asym_fifo_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_a (
      .clk_i(clk), .cke_i(cke), .rst_i(rst),
      .w_en_i(a_w_en), .w_data_i(a_w_data), .w_full_o(a_w_full),
      .r_en_i(a_r_en), .r_data_o(a_r_data), .r_valid_o(a_r_valid), .r_empty_o(a_r_empty),
      .level_o(a_level),
      .conv_w_en_o(a_cw_en), .conv_w_addr_o(a_cw_addr), .conv_w_data_o(a_cw_data),
      .conv_r_en_o(a_cr_en), .conv_r_addr_o(a_cr_addr), .conv_r_data_i(a_cr_data)
   );

   iob_asym_fifo_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_b (
      .clk_i(clk), .cke_i(cke), .rst_i(rst),
      .w_en_i(b_w_en), .w_data_i(b_w_data), .w_full_o(b_w_full),
      .r_en_i(b_r_en), .r_data_o(b_r_data), .r_valid_o(b_r_valid), .r_empty_o(b_r_empty),
      .level_o(b_level),
      .conv_w_en_o(b_cw_en), .conv_w_addr_o(b_cw_addr), .conv_w_data_o(b_cw_data),
      .conv_r_en_o(b_cr_en), .conv_r_addr_o(b_cr_addr), .conv_r_data_i(b_cr_data)
   );

   // Converter + RAM stand-in: byte-granular storage, LSB-first lanes, 1-cycle read
   logic [7:0] ram_a [16];
   logic [7:0] ram_b [16];

   always @(posedge clk) begin
      if (cke) begin
         if (a_cw_en) ram_a[a_cw_addr] <= a_cw_data;
         if (a_cr_en) a_cr_data <= {ram_a[{a_cr_addr, 2'd3}], ram_a[{a_cr_addr, 2'd2}],
                                    ram_a[{a_cr_addr, 2'd1}], ram_a[{a_cr_addr, 2'd0}]};
         if (b_cw_en) begin
            for (int k = 0; k < 4; k++) ram_b[{b_cw_addr, 2'(k)}] <= b_cw_data[8*k +: 8];
         end
         if (b_cr_en) b_cr_data <= ram_b[b_cr_addr];
      end
   end

   // Reference model: FIFO of bytes per instance plus accepted-transfer counts
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   int         wcnt [2];
   int         rcnt [2];
   bit         prev_valid [2];
   int         n_cmp = 0;
   int         n_bad = 0;
   logic       s_cw_en, s_cr_en;
   logic [31:0] s_cw_addr;

   typedef struct {
      bit          w_en;
      logic [7:0]  w_data;
      bit          r_en;
      int          level;
      bit          full;
      bit          empty;
      bit          valid;
      logic [31:0] rdata;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit w_en, logic [7:0] w_data, bit r_en, int level,
                               bit full, bit empty, bit valid, logic [31:0] rdata);
      vec_t v;
      v.w_en = w_en; v.w_data = w_data; v.r_en = r_en; v.level = level;
      v.full = full; v.empty = empty; v.valid = valid; v.rdata = rdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int model_size(input int inst);
      return (inst == 0) ? qa.size() : qb.size();
   endfunction

   task automatic model_push(input int inst, input logic [7:0] b);
      if (inst == 0) qa.push_back(b);
      else qb.push_back(b);
   endtask

   task automatic model_pop(input int inst, output logic [7:0] b);
      if (inst == 0) b = qa.pop_front();
      else b = qb.pop_front();
   endtask

   task automatic idle_inputs();
      a_w_en = 1'b0; a_r_en = 1'b0; a_w_data = '0;
      b_w_en = 1'b0; b_r_en = 1'b0; b_w_data = '0;
   endtask

   // One clock cycle on one instance; called just after a rising edge
   task automatic step(input int inst, input bit w_en, input logic [31:0] w_data, input bit r_en);
      int          wr, rd, sz;
      bit          push, pop;
      logic [31:0] exp_word;
      logic [7:0]  byt;
      wr = (inst == 0) ? 1 : 4;
      rd = (inst == 0) ? 4 : 1;
      sz = model_size(inst);
      push = w_en && (sz + wr <= 16);
      pop = r_en && (sz >= rd);
      exp_word = '0;
      idle_inputs();
      if (inst == 0) begin
         a_w_en = w_en; a_r_en = r_en; a_w_data = w_data[7:0];
      end else begin
         b_w_en = w_en; b_r_en = r_en; b_w_data = w_data;
      end
      #1;
      s_cw_en = (inst == 0) ? a_cw_en : b_cw_en;
      s_cr_en = (inst == 0) ? a_cr_en : b_cr_en;
      s_cw_addr = (inst == 0) ? 32'(a_cw_addr) : 32'(b_cw_addr);
      check("conv_w_en", 32'(s_cw_en), 32'(push));
      check("conv_r_en", 32'(s_cr_en), 32'(pop));
      if (inst == 0) begin
         if (push) check("a conv_w_addr", s_cw_addr, 32'(wcnt[0] % 16));
         if (push) check("a conv_w_data", 32'(a_cw_data), w_data & 32'hFF);
         if (pop) check("a conv_r_addr", 32'(a_cr_addr), 32'(rcnt[0] % 4));
      end else begin
         if (push) check("b conv_w_addr", s_cw_addr, 32'(wcnt[1] % 4));
         if (push) check("b conv_w_data", b_cw_data, w_data);
         if (pop) check("b conv_r_addr", 32'(b_cr_addr), 32'(rcnt[1] % 16));
      end
      if (cke) begin
         if (push) begin
            for (int k = 0; k < wr; k++) model_push(inst, w_data[8*k +: 8]);
            wcnt[inst]++;
         end
         if (pop) begin
            for (int k = 0; k < rd; k++) begin
               model_pop(inst, byt);
               exp_word[8*k +: 8] = byt;
            end
            rcnt[inst]++;
         end
         prev_valid[0] = 1'b0;
         prev_valid[1] = 1'b0;
         prev_valid[inst] = pop;
      end
      @(posedge clk);
      #1;
      sz = model_size(inst);
      if (inst == 0) begin
         check("a level", 32'(a_level), 32'(sz));
         check("a w_full", 32'(a_w_full), 32'(sz + wr > 16));
         check("a r_empty", 32'(a_r_empty), 32'(sz < rd));
         check("a r_valid", 32'(a_r_valid), 32'(prev_valid[0]));
         if (cke && pop) check("a r_data", a_r_data, exp_word);
      end else begin
         check("b level", 32'(b_level), 32'(sz));
         check("b w_full", 32'(b_w_full), 32'(sz + wr > 16));
         check("b r_empty", 32'(b_r_empty), 32'(sz < rd));
         check("b r_valid", 32'(b_r_valid), 32'(prev_valid[1]));
         if (cke && pop) check("b r_data", 32'(b_r_data), exp_word);
      end
   endtask

   // One reset cycle; a_pop drives a pop request on instance A during it
   task automatic do_reset(input bit a_pop);
      idle_inputs();
      a_r_en = a_pop;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_r_en = 1'b0;
      qa.delete();
      qb.delete();
      wcnt = '{0, 0};
      rcnt = '{0, 0};
      prev_valid = '{1'b0, 1'b0};
      check("rst a level", 32'(a_level), 32'd0);
      check("rst a r_empty", 32'(a_r_empty), 32'd1);
      check("rst a w_full", 32'(a_w_full), 32'd0);
      check("rst a r_valid", 32'(a_r_valid), 32'd0);
      check("rst b level", 32'(b_level), 32'd0);
      check("rst b r_empty", 32'(b_r_empty), 32'd1);
      check("rst b w_full", 32'(b_w_full), 32'd0);
      check("rst b r_valid", 32'(b_r_valid), 32'd0);
   endtask

   initial begin
      int pw, pr;
      cke = 1'b1;
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      do_reset(1'b0);

      // 8->32: four bytes assemble LSB-first, then fill to full, drop, and drain one word
      vt.push_back(mk(1, 8'h11, 0, 1, 0, 1, 0, 32'h0));
      vt.push_back(mk(1, 8'h22, 0, 2, 0, 1, 0, 32'h0));
      vt.push_back(mk(1, 8'h33, 0, 3, 0, 1, 0, 32'h0));
      vt.push_back(mk(1, 8'h44, 0, 4, 0, 0, 0, 32'h0));
      vt.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 32'h44332211));
      for (int i = 0; i < 16; i++) begin
         vt.push_back(mk(1, 8'(i), 0, i + 1, i == 15, i < 3, 0, 32'h0));
      end
      vt.push_back(mk(1, 8'hEE, 0, 16, 1, 0, 0, 32'h0));
      vt.push_back(mk(0, 8'h00, 1, 12, 0, 0, 1, 32'h03020100));
      foreach (vt[i]) begin
         step(0, vt[i].w_en, 32'(vt[i].w_data), vt[i].r_en);
         check("tbl level", 32'(a_level), 32'(vt[i].level));
         check("tbl w_full", 32'(a_w_full), 32'(vt[i].full));
         check("tbl r_empty", 32'(a_r_empty), 32'(vt[i].empty));
         check("tbl r_valid", 32'(a_r_valid), 32'(vt[i].valid));
         if (vt[i].valid) check("tbl r_data", a_r_data, vt[i].rdata);
      end

      // Clock enable low: requests reach the converter but nothing advances
      cke = 1'b0;
      step(0, 1'b1, 32'h77, 1'b0);
      step(0, 1'b0, 32'h0, 1'b1);
      check("cke0 level", 32'(a_level), 32'd12);
      check("cke0 r_valid held", 32'(a_r_valid), 32'd1);
      cke = 1'b1;

      // 32->8: one word pops as four bytes, fifth pop dropped
      do_reset(1'b0);
      step(1, 1'b1, 32'hDDCCBBAA, 1'b0);
      check("b level after push", 32'(b_level), 32'd4);
      for (int k = 0; k < 4; k++) begin
         step(1, 1'b0, 32'h0, 1'b1);
         check("b pop byte", 32'(b_r_data), 32'(8'hAA) + 32'(17 * k));
      end
      step(1, 1'b0, 32'h0, 1'b1);
      check("b 5th pop r_valid", 32'(b_r_valid), 32'd0);
      check("b 5th pop r_empty", 32'(b_r_empty), 32'd1);

      // Simultaneous push/pop at level 4 and at the full threshold (level 12)
      step(1, 1'b1, 32'h04030201, 1'b0);
      step(1, 1'b1, 32'h08070605, 1'b1);
      check("b push+pop level", 32'(b_level), 32'd7);
      check("b push+pop w_en", 32'(s_cw_en), 32'd1);
      check("b push+pop r_en", 32'(s_cr_en), 32'd1);
      repeat (3) step(1, 1'b0, 32'h0, 1'b1);
      step(1, 1'b1, 32'h0C0B0A09, 1'b0);
      step(1, 1'b1, 32'h100F0E0D, 1'b0);
      check("b level 12 not full", 32'(b_w_full), 32'd0);
      step(1, 1'b1, 32'h14131211, 1'b1);
      check("b at-threshold level", 32'(b_level), 32'd15);
      check("b at-threshold full", 32'(b_w_full), 32'd1);
      step(1, 1'b1, 32'hFFFFFFFF, 1'b1);

      // 8->32: 40 bytes through a 16-byte FIFO so both pointers wrap
      do_reset(1'b0);
      for (int i = 0; i < 10; i++) begin
         for (int k = 0; k < 4; k++) step(0, 1'b1, 32'(4 * i + k), 1'b0);
         step(0, 1'b0, 32'h0, 1'b1);
         check("wrap word", a_r_data, 32'h03020100 + 32'h04040404 * 32'(i));
      end

      // Reset with level 8 while popping; following push restarts at address 0
      do_reset(1'b0);
      for (int k = 0; k < 8; k++) step(0, 1'b1, 32'(8'hA0 + k), 1'b0);
      check("pre-reset level", 32'(a_level), 32'd8);
      do_reset(1'b1);
      step(0, 1'b1, 32'h5A, 1'b0);
      check("post-reset w_addr", s_cw_addr, 32'd0);

      // Randomized traffic alternating fill-heavy and drain-heavy phases
      for (int inst = 0; inst < 2; inst++) begin
         for (int ph = 0; ph < 4; ph++) begin
            pw = (ph % 2 == 0) ? 75 : 30;
            pr = 100 - pw;
            for (int c = 0; c < 120; c++) begin
               cke = ($urandom_range(0, 15) != 0);
               step(inst, $urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pr);
            end
         end
      end
      cke = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
